// File: rtl/ysyx_23060020_mem_arbiter.sv
// ysyx_23060020_mem_arbiter
// Shares the single memory port between the IFU (read-only) and the LSU
// (read/write). One transaction is outstanding at a time. A programmable
// idle latency runs between acceptance and the one-cycle memory strobe.
// The read data is held in a per-requester register until the response
// is accepted.
//
// Optional build macro: ARB_RR_EN
//   defined   : round-robin arbitration with a last-grant register
//               (the LSU wins the first tie after reset; LSU_PRIO unused)
//   undefined : fixed priority selected by LSU_PRIO
//
// Parameters:
//   LATENCY  : idle cycles between acceptance and mem_valid (0..15)
//   LSU_PRIO : fixed-priority tie winner, 1 = LSU, 0 = IFU
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ifu_req_* / ifu_addr               IFU read request channel
//   ifu_rsp_* / ifu_rdata              IFU read response channel
//   lsu_req_* / lsu_addr/wen/wdata/wmask  LSU request channel
//   lsu_rsp_* / lsu_rdata              LSU response (read data / write ack)
//   mem_valid/wen/wmask/add/wdata      memory port, nonzero only in ACCESS
//   mem_rdata                          memory read data (combinational)
//
// state  | meaning
// IDLE   | no transaction; grant is combinational from the request valids
// DELAY  | latency countdown, leaves when the counter reaches 0
// ACCESS | one-cycle mem_valid strobe; read data captured for the owner
// RESP   | owner's rsp_valid high until rsp_ready
module ysyx_23060020_mem_arbiter #(
   parameter int unsigned LATENCY  = 1,
   parameter bit          LSU_PRIO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_rsp_valid,
   input  logic        ifu_rsp_ready,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_rsp_valid,
   input  logic        lsu_rsp_ready,
   output logic [31:0] lsu_rdata,
   output logic        mem_valid,
   output logic        mem_wen,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_add,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, DELAY, ACCESS, RESP} state_t;

   localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_lsu_q;
   logic [31:0] addr_q, wdata_q;
   logic        wen_q;
   logic [3:0]  wmask_q;
   logic [31:0] ifu_rdata_q, lsu_rdata_q;
   logic        grant_lsu;
   logic        in_idle;
   logic        accept;

`ifdef ARB_RR_EN
   // Holds 1 when the LSU was granted last; reset to IFU so the LSU wins the first tie.
   logic last_lsu_q;
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);
`else
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | LSU_PRIO);
`endif

   // Readies are gated by rst_n so that nothing is offered while reset is held.
   assign in_idle       = (state_q == IDLE) & rst_n;
   assign lsu_req_ready = in_idle & grant_lsu;
   assign ifu_req_ready = in_idle & ifu_req_valid & ~grant_lsu;
   assign accept        = lsu_req_ready | ifu_req_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (LATENCY == 0) ? ACCESS : DELAY;
               cnt_d   = CNT_INIT;
            end
         end
         DELAY: begin
            if (cnt_q == 4'd0) state_d = ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ACCESS: state_d = RESP;
         RESP: begin
            if (owner_lsu_q ? lsu_rsp_ready : ifu_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         owner_lsu_q <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         wen_q       <= 1'b0;
         wmask_q     <= 4'd0;
         ifu_rdata_q <= 32'd0;
         lsu_rdata_q <= 32'd0;
`ifdef ARB_RR_EN
         last_lsu_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            owner_lsu_q <= lsu_req_ready;
            addr_q      <= lsu_req_ready ? lsu_addr : ifu_addr;
            wen_q       <= lsu_req_ready & lsu_wen;
            wmask_q     <= lsu_req_ready ? lsu_wmask : 4'd0;
            wdata_q     <= lsu_req_ready ? lsu_wdata : 32'd0;
`ifdef ARB_RR_EN
            last_lsu_q  <= lsu_req_ready;
`endif
         end
         if (state_q == ACCESS) begin
            if (owner_lsu_q) lsu_rdata_q <= wen_q ? 32'd0 : mem_rdata;
            else             ifu_rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_valid = (state_q == ACCESS);
   assign mem_wen   = mem_valid & wen_q;
   assign mem_wmask = {4{mem_valid}} & wmask_q;
   assign mem_add   = {32{mem_valid}} & addr_q;
   assign mem_wdata = {32{mem_valid}} & wdata_q;

   assign ifu_rsp_valid = (state_q == RESP) & ~owner_lsu_q;
   assign lsu_rsp_valid = (state_q == RESP) &  owner_lsu_q;
   assign ifu_rdata     = ifu_rdata_q;
   assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_23060020_mem_arbiter.sv
// Directed bench for ysyx_23060020_mem_arbiter. Two instances: u_dut with
// LATENCY=1, LSU_PRIO=1 and u_dut0 with LATENCY=0. Inputs change on the
// falling edge; outputs are sampled on the falling edge (or #1 after it).
module tb_ysyx_23060020_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_valid, mem_wen;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_add, mem_wdata, mem_rdata;

   logic        ifu_req_valid_0, ifu_req_ready_0, ifu_rsp_valid_0, ifu_rsp_ready_0;
   logic [31:0] ifu_addr_0, ifu_rdata_0;
   logic        lsu_req_valid_0, lsu_req_ready_0, lsu_wen_0, lsu_rsp_valid_0, lsu_rsp_ready_0;
   logic [31:0] lsu_addr_0, lsu_wdata_0, lsu_rdata_0;
   logic [3:0]  lsu_wmask_0;
   logic        mem_valid_0, mem_wen_0;
   logic [3:0]  mem_wmask_0;
   logic [31:0] mem_add_0, mem_wdata_0, mem_rdata_0;

   int passed = 0;
   int total  = 0;
   int pulses = 0;
   int snap;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_0000);
   endfunction

   assign mem_rdata   = mem_valid   ? memf(mem_add)   : 32'd0;
   assign mem_rdata_0 = mem_valid_0 ? memf(mem_add_0) : 32'd0;

   always @(posedge clk) if (mem_valid) pulses++;

   ysyx_23060020_mem_arbiter #(.LATENCY(1), .LSU_PRIO(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
      .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
      .mem_add(mem_add), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   ysyx_23060020_mem_arbiter #(.LATENCY(0), .LSU_PRIO(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid_0), .ifu_req_ready(ifu_req_ready_0), .ifu_addr(ifu_addr_0),
      .ifu_rsp_valid(ifu_rsp_valid_0), .ifu_rsp_ready(ifu_rsp_ready_0), .ifu_rdata(ifu_rdata_0),
      .lsu_req_valid(lsu_req_valid_0), .lsu_req_ready(lsu_req_ready_0), .lsu_addr(lsu_addr_0),
      .lsu_wen(lsu_wen_0), .lsu_wdata(lsu_wdata_0), .lsu_wmask(lsu_wmask_0),
      .lsu_rsp_valid(lsu_rsp_valid_0), .lsu_rsp_ready(lsu_rsp_ready_0), .lsu_rdata(lsu_rdata_0),
      .mem_valid(mem_valid_0), .mem_wen(mem_wen_0), .mem_wmask(mem_wmask_0),
      .mem_add(mem_add_0), .mem_wdata(mem_wdata_0), .mem_rdata(mem_rdata_0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 1;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_rsp_ready = 1;
      ifu_req_valid_0 = 0; ifu_addr_0 = 0; ifu_rsp_ready_0 = 1;
      lsu_req_valid_0 = 0; lsu_addr_0 = 0; lsu_wen_0 = 0; lsu_wdata_0 = 0; lsu_wmask_0 = 0;
      lsu_rsp_ready_0 = 1;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      check("rst_rsp_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
      check("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
      check("rst_mem", {26'd0, mem_valid, mem_wen, mem_wmask} | mem_add | mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // IFU read, LATENCY=1
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
      #1;
      check("ifu_rd_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd2);
      @(negedge clk); ifu_req_valid = 0;
      check("ifu_rd_delay_no_strobe", {31'd0, mem_valid}, 32'd0);
      @(negedge clk);
      check("ifu_rd_strobe", {31'd0, mem_valid}, 32'd1);
      check("ifu_rd_addr", mem_add, 32'h8000_0000);
      check("ifu_rd_wen", {27'd0, mem_wen, mem_wmask}, 32'd0);
      @(negedge clk);
      check("ifu_rd_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd1);
      check("ifu_rd_rdata", ifu_rdata, 32'h0000_0413);
      check("ifu_rd_strobe_gone", {31'd0, mem_valid}, 32'd0);
      @(negedge clk);
      check("ifu_rd_rsp_drop", {31'd0, ifu_rsp_valid}, 32'd0);
      check("ifu_rd_pulses", pulses, 32'd1);

      // LSU write
      lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;
      #1;
      check("lsu_wr_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd1);
      @(negedge clk); lsu_req_valid = 0; lsu_wen = 0;
      @(negedge clk);
      check("lsu_wr_strobe", {26'd0, mem_valid, mem_wen, mem_wmask}, {26'd0, 2'b11, 4'h3});
      check("lsu_wr_addr", mem_add, 32'h8000_1000);
      check("lsu_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      check("lsu_wr_rsp", {30'd0, lsu_rsp_valid, ifu_rsp_valid}, 32'd2);
      check("lsu_wr_rdata_zero", lsu_rdata, 32'd0);
      @(negedge clk);
      check("lsu_wr_pulses", pulses, 32'd2);

      // simultaneous requests; reset first so the round-robin state is known
      rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);
      ifu_req_valid = 1; ifu_addr = 32'h0000_0200;
      lsu_req_valid = 1; lsu_addr = 32'h0000_0100;
      for (int i = 0; i < 4; i++) begin
         logic exp_lsu;
`ifdef ARB_RR_EN
         exp_lsu = (i % 2 == 0);
`else
         if (i >= 2) lsu_req_valid = 0;
         exp_lsu = (i < 2);
`endif
         #1;
         check($sformatf("tie_grant_%0d", i), {30'd0, ifu_req_ready, lsu_req_ready},
               exp_lsu ? 32'd1 : 32'd2);
         repeat (4) @(negedge clk);
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      @(negedge clk);

      // response back-pressure
      ifu_req_valid = 1; ifu_addr = 32'h8000_0004; ifu_rsp_ready = 0;
      #1;
      check("bp_ready", {31'd0, ifu_req_ready}, 32'd1);
      @(negedge clk); lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0040;
      repeat (2) @(negedge clk);
      snap = pulses;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("bp_rsp_valid_%0d", k), {31'd0, ifu_rsp_valid}, 32'd1);
         check($sformatf("bp_rdata_%0d", k), ifu_rdata, 32'h25A5_0004);
         check($sformatf("bp_no_ready_%0d", k),
               {29'd0, ifu_req_ready, lsu_req_ready, mem_valid}, 32'd0);
         @(negedge clk);
      end
      check("bp_no_pulse", pulses, snap);
      ifu_req_valid = 0; lsu_req_valid = 0; ifu_rsp_ready = 1;
      @(negedge clk);
      check("bp_rsp_drop", {31'd0, ifu_rsp_valid}, 32'd0);

      // LATENCY=0 instance
      ifu_req_valid_0 = 1; ifu_addr_0 = 32'h8000_0000;
      #1;
      check("lat0_ready", {31'd0, ifu_req_ready_0}, 32'd1);
      @(negedge clk); ifu_req_valid_0 = 0;
      check("lat0_strobe", {31'd0, mem_valid_0}, 32'd1);
      check("lat0_addr", mem_add_0, 32'h8000_0000);
      @(negedge clk);
      check("lat0_rsp", {30'd0, ifu_rsp_valid_0, mem_valid_0}, 32'd2);
      check("lat0_rdata", ifu_rdata_0, 32'h0000_0413);
      @(negedge clk);

      // reset during DELAY
      ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
      #1;
      check("rd_ready", {31'd0, ifu_req_ready}, 32'd1);
      @(negedge clk);
      snap = pulses;
      rst_n = 0;
      #1;
      check("rd_outputs_zero",
            {26'd0, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_valid, mem_wen},
            32'd0);
      check("rd_rdata_zero", ifu_rdata | lsu_rdata | mem_add, 32'd0);
      @(negedge clk); rst_n = 1; ifu_req_valid = 0;
      repeat (4) @(negedge clk);
      check("rd_no_pulse", pulses, snap);
      lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0010;
      #1;
      check("rd_fresh_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd1);
      @(negedge clk); lsu_req_valid = 0;
      @(negedge clk);
      check("rd_fresh_strobe", {31'd0, mem_valid}, 32'd1);
      @(negedge clk);
      check("rd_fresh_rsp", {31'd0, lsu_rsp_valid}, 32'd1);
      check("rd_fresh_rdata", lsu_rdata, 32'h25A5_0010);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
